// File: rtl/grover_diffuse_engine.sv
`default_nettype none
// ============================================================================
// Module   : grover_diffuse_engine
// Purpose  : Runs N Grover iterations (oracle phase flip of the marked basis
//            state, then inversion about the mean) on eight signed Q1.6
//            amplitudes and streams each iteration's result to the amplitude
//            register bank with a one-cycle load strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   start    in   begin a run (sampled only while idle)
//   marked   in   [2:0] oracle-marked index, captured at start
//   iters    in   [ITER_BITS-1:0] iteration count, captured at start
//   a0..a7   in   signed current amplitudes (read only when a run begins)
//   n0..n7   out  signed new amplitudes, registered, held until overwritten
//   load_en  out  one-cycle strobe to the register bank enable
//   busy     out  high whenever a run is in progress
//   done     out  one-cycle pulse at the end of a run
// ----------------------------------------------------------------------------
// Build option
//   GROVER_SAT_EN  defined   : diffusion results saturate to the 8-bit range
//                              and negating -128 yields 127
//                  undefined : results wrap (two's complement) and negating
//                              -128 yields -128
// ============================================================================
module grover_diffuse_engine #(
   parameter int SAMPLE_SIZE    = 8,
   parameter int COMPLEXNUM_BIT = 8,
   parameter int ITER_BITS      = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [2:0]                       marked,
   input  logic [ITER_BITS-1:0]             iters,
   input  logic signed [COMPLEXNUM_BIT-1:0] a0,
   input  logic signed [COMPLEXNUM_BIT-1:0] a1,
   input  logic signed [COMPLEXNUM_BIT-1:0] a2,
   input  logic signed [COMPLEXNUM_BIT-1:0] a3,
   input  logic signed [COMPLEXNUM_BIT-1:0] a4,
   input  logic signed [COMPLEXNUM_BIT-1:0] a5,
   input  logic signed [COMPLEXNUM_BIT-1:0] a6,
   input  logic signed [COMPLEXNUM_BIT-1:0] a7,
   output logic signed [COMPLEXNUM_BIT-1:0] n0,
   output logic signed [COMPLEXNUM_BIT-1:0] n1,
   output logic signed [COMPLEXNUM_BIT-1:0] n2,
   output logic signed [COMPLEXNUM_BIT-1:0] n3,
   output logic signed [COMPLEXNUM_BIT-1:0] n4,
   output logic signed [COMPLEXNUM_BIT-1:0] n5,
   output logic signed [COMPLEXNUM_BIT-1:0] n6,
   output logic signed [COMPLEXNUM_BIT-1:0] n7,
   output logic                             load_en,
   output logic                             busy,
   output logic                             done
);

   localparam int CW    = COMPLEXNUM_BIT;
   localparam int ACC_W = COMPLEXNUM_BIT + 3;   // sum of eight amplitudes

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_ORACLE  = 3'd2;
   localparam logic [2:0] ST_ACCUM   = 3'd3;
   localparam logic [2:0] ST_DIFFUSE = 3'd4;
   localparam logic [2:0] ST_WRITE   = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

`ifdef GROVER_SAT_EN
   localparam int TW = COMPLEXNUM_BIT + 2;      // holds 2*mean - w without loss
   localparam logic signed [CW-1:0] AMP_MAX = {1'b0, {(CW-1){1'b1}}};
   localparam logic signed [CW-1:0] AMP_MIN = {1'b1, {(CW-1){1'b0}}};
   localparam logic signed [TW-1:0] T_MAX   = {2'b00, AMP_MAX};
   localparam logic signed [TW-1:0] T_MIN   = {2'b11, AMP_MIN};
`endif

   logic [2:0]                    state;
   logic [2:0]                    next_state;

   logic signed [CW-1:0]          a_vec   [SAMPLE_SIZE];
   logic signed [CW-1:0]          w       [SAMPLE_SIZE];
   logic signed [CW-1:0]          nv      [SAMPLE_SIZE];
   logic signed [CW-1:0]          clipped [SAMPLE_SIZE];
   logic signed [ACC_W-1:0]       acc;
   logic signed [CW-1:0]          mean;
   logic [2:0]                    idx;
   logic [ITER_BITS-1:0]          iter_cnt;
   logic [2:0]                    marked_reg;
   logic [ITER_BITS-1:0]          iters_reg;

   // Oracle phase flip. -128 has no positive counterpart in 8 bits.
   function automatic logic signed [CW-1:0] negate(input logic signed [CW-1:0] x);
`ifdef GROVER_SAT_EN
      if (x == AMP_MIN) begin
         negate = AMP_MAX;
      end else begin
         negate = -x;
      end
`else
      negate = -x;
`endif
   endfunction

   assign a_vec[0] = a0;
   assign a_vec[1] = a1;
   assign a_vec[2] = a2;
   assign a_vec[3] = a3;
   assign a_vec[4] = a4;
   assign a_vec[5] = a5;
   assign a_vec[6] = a6;
   assign a_vec[7] = a7;

   assign n0 = nv[0];
   assign n1 = nv[1];
   assign n2 = nv[2];
   assign n3 = nv[3];
   assign n4 = nv[4];
   assign n5 = nv[5];
   assign n6 = nv[6];
   assign n7 = nv[7];

   // Dropping the low three bits is an arithmetic shift by 3 (floor of sum/8);
   // the eight-entry sum always fits the result in CW bits.
   assign mean = acc[ACC_W-1:3];

   // Inversion about the mean for every entry in parallel.
   genvar k;
   generate
      for (k = 0; k < SAMPLE_SIZE; k++) begin : g_diffuse
`ifdef GROVER_SAT_EN
         logic signed [TW-1:0] t;
         assign t = $signed({mean[CW-1], mean, 1'b0}) - $signed({{2{w[k][CW-1]}}, w[k]});
         assign clipped[k] = (t > T_MAX) ? AMP_MAX :
                             (t < T_MIN) ? AMP_MIN : t[CW-1:0];
`else
         // Keeping only the low CW bits of the wide result is identical to
         // computing modulo 2^CW directly.
         assign clipped[k] = mean + mean - w[k];
`endif
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (start) next_state = ST_LOAD;
         ST_LOAD:    next_state = (iters_reg == '0) ? ST_DONE : ST_ORACLE;
         ST_ORACLE:  next_state = ST_ACCUM;
         ST_ACCUM:   if (idx == 3'd7) next_state = ST_DIFFUSE;
         ST_DIFFUSE: next_state = ST_WRITE;
         ST_WRITE:   next_state = ((iter_cnt + ITER_BITS'(1)) == iters_reg) ? ST_DONE : ST_ORACLE;
         ST_DONE:    next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs, decoded from the state register so they are glitch-free
   // and drop together with an asynchronous reset.
   // ------------------------------------------------------------------------
   always_comb begin
      busy    = (state != ST_IDLE);
      load_en = (state == ST_WRITE);
      done    = (state == ST_DONE);
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SAMPLE_SIZE; i++) begin
            w[i]  <= '0;
            nv[i] <= '0;
         end
         acc        <= '0;
         idx        <= '0;
         iter_cnt   <= '0;
         marked_reg <= '0;
         iters_reg  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  marked_reg <= marked;
                  iters_reg  <= iters;
               end
            end
            ST_LOAD: begin
               for (int i = 0; i < SAMPLE_SIZE; i++) begin
                  w[i] <= a_vec[i];
               end
               iter_cnt <= '0;
            end
            ST_ORACLE: begin
               w[marked_reg] <= negate(w[marked_reg]);
               acc           <= '0;
               idx           <= '0;
            end
            ST_ACCUM: begin
               acc <= acc + $signed({{3{w[idx][CW-1]}}, w[idx]});
               idx <= idx + 3'd1;
            end
            ST_DIFFUSE: begin
               for (int i = 0; i < SAMPLE_SIZE; i++) begin
                  w[i]  <= clipped[i];
                  nv[i] <= clipped[i];
               end
            end
            ST_WRITE: begin
               iter_cnt <= iter_cnt + ITER_BITS'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_grover_diffuse_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_grover_diffuse_engine
// Purpose  : Self-checking bench for grover_diffuse_engine: directed vector
//            table, hand-written reset / restart sequences and randomized runs
//            compared against an arithmetic reference of Grover iteration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grover_diffuse_engine;

   logic              clk;
   logic              rst;
   logic              start;
   logic [2:0]        marked;
   logic [3:0]        iters;
   logic signed [7:0] av   [8];
   logic signed [7:0] nout [8];
   logic              load_en;
   logic              busy;
   logic              done;

   int n_tests = 0;
   int n_fail  = 0;

   grover_diffuse_engine dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .marked  (marked),
      .iters   (iters),
      .a0      (av[0]),
      .a1      (av[1]),
      .a2      (av[2]),
      .a3      (av[3]),
      .a4      (av[4]),
      .a5      (av[5]),
      .a6      (av[6]),
      .a7      (av[7]),
      .n0      (nout[0]),
      .n1      (nout[1]),
      .n2      (nout[2]),
      .n3      (nout[3]),
      .n4      (nout[4]),
      .n5      (nout[5]),
      .n6      (nout[6]),
      .n7      (nout[7]),
      .load_en (load_en),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int a [8];
      int marked;
      int iters;
      int exp [8];
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) -------------
   function automatic int clip8(input int t);
`ifdef GROVER_SAT_EN
      if (t > 127) return 127;
      if (t < -128) return -128;
      return t;
`else
      int r;
      r = ((t % 256) + 256) % 256;
      return (r > 127) ? r - 256 : r;
`endif
   endfunction

   function automatic int neg8(input int x);
      return clip8(-x);
   endfunction

   function automatic int floor_div8(input int s);
      return (s - (((s % 8) + 8) % 8)) / 8;
   endfunction

   task automatic model(input int a[8], input int m, input int it, output int r[8]);
      int sum;
      int mean;
      r = a;
      for (int j = 0; j < it; j++) begin
         r[m] = neg8(r[m]);
         sum = 0;
         for (int i = 0; i < 8; i++) sum += r[i];
         mean = floor_div8(sum);
         for (int i = 0; i < 8; i++) r[i] = clip8(2 * mean - r[i]);
      end
   endtask

   // ---------------- one complete run with timing checks --------------------
   // Edge 1 is the edge that samples start; e counts edges, signals are
   // observed 1 time unit after each edge.
   task automatic run_case(input int a[8], input int m, input int it,
                           input bit disturb, output int got[8]);
      int e;
      int np;
      int done_e;
      @(negedge clk);
      for (int i = 0; i < 8; i++) av[i] = 8'(a[i]);
      marked = 3'(m);
      iters  = 4'(it);
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      e = 1; np = 0; done_e = -1;
      check("busy_after_start", int'(busy), 1);
      while (e < 400) begin
         if (disturb && e == 5) begin
            // A second start mid-run with different inputs must change nothing.
            start  = 1'b1;
            marked = ~marked;
            iters  = 4'd9;
            for (int i = 0; i < 8; i++) av[i] = ~av[i];
         end
         if (disturb && e == 6) start = 1'b0;
         if (load_en) begin
            check("load_en_edge", e, 12 + 11 * np);
            np++;
         end
         if (done) begin
            done_e = e;
            break;
         end
         @(posedge clk); #1;
         e++;
      end
      check("done_edge", done_e, (it == 0) ? 2 : 13 + 11 * (it - 1));
      check("load_en_count", np, it);
      @(posedge clk); #1;
      check("idle_after_done", int'({busy, done, load_en}), 0);
      for (int i = 0; i < 8; i++) got[i] = int'(nout[i]);
   endtask

   vec_t tbl [4];
   int   got  [8];
   int   prev [8];
   int   expv [8];
   int   ra   [8];
   int   rm;
   int   rit;
   int   hits;

   initial begin
      rst = 1'b0; start = 1'b0; marked = '0; iters = '0;
      for (int i = 0; i < 8; i++) av[i] = '0;

      // ---- vector table ----
      tbl[0].a = '{23, 23, 23, 23, 23, 23, 23, 23};
      tbl[0].marked = 5; tbl[0].iters = 1;
      tbl[0].exp = '{11, 11, 11, 11, 11, 57, 11, 11};
      // iters=0 leaves n untouched even though a differs
      tbl[1].a = '{1, 2, 3, 4, 5, 6, 7, 8};
      tbl[1].marked = 2; tbl[1].iters = 0;
      tbl[1].exp = '{11, 11, 11, 11, 11, 57, 11, 11};
      tbl[2].a = '{23, 23, 23, 23, 23, 23, 23, 23};
      tbl[2].marked = 5; tbl[2].iters = 2;
      tbl[2].exp = '{-7, -7, -7, -7, -7, 61, -7, -7};
      tbl[3].a = '{-128, 127, 127, 127, 127, 127, 127, 127};
      tbl[3].marked = 0; tbl[3].iters = 1;
`ifdef GROVER_SAT_EN
      tbl[3].exp = '{127, 127, 127, 127, 127, 127, 127, 127};
`else
      tbl[3].exp = '{62, 63, 63, 63, 63, 63, 63, 63};
`endif

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_load_en", int'(load_en), 0);
      check("reset_done", int'(done), 0);
      check("reset_n3", int'(nout[3]), 0);
      rst = 1'b1;

      for (int t = 0; t < 4; t++) begin
         run_case(tbl[t].a, tbl[t].marked, tbl[t].iters, 1'b0, got);
         for (int i = 0; i < 8; i++)
            check($sformatf("tbl%0d_n%0d", t, i), got[i], tbl[t].exp[i]);
         prev = got;
      end

      // ---- reset in the middle of ACCUM ----
      @(negedge clk);
      for (int i = 0; i < 8; i++) av[i] = 8'sd5;
      marked = 3'd1; iters = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("busy_before_abort", int'(busy), 1);
      rst = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_load_en", int'(load_en), 0);
      check("abort_done", int'(done), 0);
      for (int i = 0; i < 8; i++) check($sformatf("abort_n%0d", i), int'(nout[i]), 0);
      @(negedge clk);
      rst = 1'b1;
      hits = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (load_en || busy || done) hits++;
      end
      check("quiet_after_abort", hits, 0);
      prev = '{0, 0, 0, 0, 0, 0, 0, 0};

      // ---- start while busy, then rerun from current inputs ----
      ra = '{10, -20, 30, -40, 50, -60, 70, -80};
      run_case(ra, 3, 2, 1'b1, got);
      model(ra, 3, 2, expv);
      for (int i = 0; i < 8; i++) check($sformatf("busy_start_n%0d", i), got[i], expv[i]);
      ra = '{-5, 17, 99, -100, 0, 64, -64, 3};
      run_case(ra, 6, 1, 1'b0, got);
      model(ra, 6, 1, expv);
      for (int i = 0; i < 8; i++) check($sformatf("rerun_n%0d", i), got[i], expv[i]);
      prev = got;

      // ---- randomized runs against the reference model ----
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < 8; i++) ra[i] = int'($urandom_range(0, 255)) - 128;
         if (c < 3) ra[$urandom_range(0, 7)] = -128;
         rm  = int'($urandom_range(0, 7));
         rit = int'($urandom_range(0, 4));
         run_case(ra, rm, rit, (rit > 0) && ($urandom_range(0, 3) == 0), got);
         if (rit == 0) expv = prev;
         else model(ra, rm, rit, expv);
         for (int i = 0; i < 8; i++) check($sformatf("rand%0d_n%0d", c, i), got[i], expv[i]);
         prev = got;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/grover_diffuse_engine.md
Name: grover_diffuse_engine

Overview:
- Iteration engine feeding the 8-entry amplitude register bank of the Grover search model.
- Takes the eight signed 8-bit amplitudes read back from the bank and runs N Grover iterations on them.
- Each iteration is an oracle phase-flip of the marked state, then diffusion (inversion about the mean).
- After every iteration it presents the new amplitudes plus a one-cycle load strobe that drives the bank's en input.

Parameters:
- sample_size, 8, number of basis-state amplitudes (fixed 8 for 3 qubits; the index is 3 bits).
- complexnum_bit, 8, amplitude width, signed two's complement, Q1.6 (1.0 = 64).
- iter_bits, 4, width of the iteration-count input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- start  in  1  begin a run; sampled only in IDLE.
- marked  in  3  index of the oracle-marked state; captured at start.
- iters  in  iter_bits  number of iterations; captured at start.
- a0..a7  in  8 each  signed current amplitudes (register bank outputs).
- n0..n7  out  8 each  signed new amplitudes (register bank inputs), registered.
- load_en  out  1  one-cycle strobe, connected to the register bank en.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of the run.

Behaviour:
- Reset (rst=0, asynchronous) drives state to IDLE.
  - n0..n7, working regs w0..w7, accumulator and counters all 0.
  - load_en, busy and done all 0.
  - Reset mid-run aborts immediately, with no partial load_en.
- States: IDLE, LOAD, ORACLE, ACCUM, DIFFUSE, WRITE, DONE.
- IDLE:
  - start=1 captures marked and iters, then moves to LOAD.
  - start is ignored in all other states.
- LOAD (1 cycle):
  - w_k <= a_k; iteration counter <= 0.
  - If captured iters==0, go to DONE; otherwise go to ORACLE.
- ORACLE (1 cycle): w[marked] <= -w[marked]; accumulator <= 0.
- ACCUM (8 cycles): index 0..7, adds sign-extended w[idx] into an 11-bit signed accumulator, one entry per cycle.
- DIFFUSE (1 cycle):
  - mean = acc >>> 3 (arithmetic shift, floor), 8-bit signed.
  - For each k: t_k = 2*mean - w_k, computed at 10 bits signed.
  - w_k <= clip8(t_k); n_k <= clip8(t_k).
  - load_en is registered high for the following cycle.
- WRITE (1 cycle):
  - load_en=1 in this cycle only.
  - Iteration counter increments.
  - If counter+1 == iters, go to DONE; otherwise go to ORACLE.
- DONE (1 cycle): done=1, then IDLE.
- Timing:
  - First load_en is high in the cycle after the 12th rising edge, counting the edge that samples start as edge 1.
  - Subsequent load_en pulses are every 11 cycles.
  - done is high in the cycle after the final WRITE cycle.
  - For iters=0, done is high 2 cycles after start is sampled.
- Later iterations use the internal w_k; a0..a7 are read only in LOAD.
- n0..n7 hold their value between updates and across runs until overwritten.

Optional Feature:
- Macro: GROVER_SAT_EN.
- Defined: clip8 saturates to [-128, 127], and the oracle negation of -128 gives 127.
- Undefined: clip8 keeps the low 8 bits (two's-complement wrap), and the oracle negation of -128 stays -128.

Test Plan:
- Reset: rst=0 mid-ACCUM → all outputs 0 and busy=0 immediately; after release, no load_en appears until a new start.
- Single iteration: all a=23, marked=5, iters=1.
  - Oracle gives sum=138, mean=17.
  - Expect n5=57, others=11, one load_en 12 cycles after start, then done.
- Two iterations: as above with iters=2.
  - Second pass: sum=20, mean=2.
  - Expect final n5=61, others=-7, two load_en pulses 11 cycles apart, then done.
- iters=0: start → done at cycle 2, no load_en, n0..n7 unchanged.
- Overflow: a0=-128, a1..a7=127, marked=0, iters=1.
  - With GROVER_SAT_EN: all n=127.
  - Without it: sum=761, mean=95; n1..n7=63, n0=62.
- Start while busy: a second start pulse mid-run is ignored; a new start after done reruns correctly from the current a0..a7.
